sram_controller: RTL and testbench

- Multi-cycle controller between the EXE/MEM pipeline boundary and an external 16-bit asynchronous SRAM.
- Takes 32-bit word read/write requests: the address is the EXE ALU result, the write data is the forwarded Rm value.
- Sequences each request as two 16-bit half-word accesses with programmable wait states.
- Drives `ready` low while busy; the hazard/freeze logic uses it to stall the pipeline.

---
 rtl/sram_controller_if.sv | 25 ++
 rtl/sram_controller.sv | 126 ++++++++++++
 tb/tb_sram_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sram_controller_if.sv
// CPU-side request/response and SRAM-side bus signals of sram_controller.
// The master side is the pipeline plus the external SRAM; the slave side is the controller.
interface sram_controller_if;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;

   modport master (
      output wr_en, rd_en, address, write_data, sram_dq_in,
      input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );

   modport slave (
      input  wr_en, rd_en, address, write_data, sram_dq_in,
      output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_controller.sv
// Word-to-half-word sequencer for a 16-bit asynchronous SRAM with programmable wait states.
// ready is low while a request is in flight so the pipeline freezes until DONE.
module sram_controller #(
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   sram_controller_if.slave  bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] LOW  = 2'd1;
   localparam logic [1:0] HIGH = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        op_wr_q, op_wr_d;
   logic [16:0] word_q, word_d;
   logic [15:0] wdata_hi_q, wdata_hi_d;
   logic [31:0] read_data_q, read_data_d;
   logic [17:0] sram_addr_q, sram_addr_d;
   logic [15:0] dq_out_q, dq_out_d;
   logic        dq_oe_q, dq_oe_d;
   logic        we_n_q, we_n_d;

   logic [31:0] off;
   logic        req;
   logic        last;
   logic        unused_off;

   // Wrap-around offset; only bits [18:2] select the SRAM word, so out-of-range addresses alias.
   assign off        = bus.address - 32'(BASE_ADDR);
   assign unused_off = ^{off[31:19], off[1:0]};
   assign req        = bus.wr_en | bus.rd_en;
   assign last       = (cnt_q == LAST);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_wr_d     = op_wr_q;
      word_d      = word_q;
      wdata_hi_d  = wdata_hi_q;
      read_data_d = read_data_q;
      sram_addr_d = sram_addr_q;
      dq_out_d    = dq_out_q;
      dq_oe_d     = dq_oe_q;
      we_n_d      = we_n_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               // Write wins when both requests are set; bus outputs for the low half are
               // registered here so they are valid on the first LOW cycle.
               op_wr_d     = bus.wr_en;
               word_d      = off[18:2];
               wdata_hi_d  = bus.write_data[31:16];
               cnt_d       = 4'd0;
               state_d     = LOW;
               sram_addr_d = {off[18:2], 1'b0};
               if (bus.wr_en) dq_out_d = bus.write_data[15:0];
               dq_oe_d     = bus.wr_en;
               we_n_d      = ~bus.wr_en;
            end
         end
         LOW: begin
            cnt_d = cnt_q + 4'd1;
            if (last) begin
               if (!op_wr_q) read_data_d[15:0] = bus.sram_dq_in;
               cnt_d       = 4'd0;
               state_d     = HIGH;
               sram_addr_d = {word_q, 1'b1};
               // we_n stays low across the half boundary; the SRAM latches on address change.
               if (op_wr_q) dq_out_d = wdata_hi_q;
            end
         end
         HIGH: begin
            cnt_d = cnt_q + 4'd1;
            if (last) begin
               if (!op_wr_q) read_data_d[31:16] = bus.sram_dq_in;
               cnt_d   = 4'd0;
               state_d = DONE;
               dq_oe_d = 1'b0;
               we_n_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         op_wr_q     <= 1'b0;
         word_q      <= 17'd0;
         wdata_hi_q  <= 16'd0;
         read_data_q <= 32'd0;
         sram_addr_q <= 18'd0;
         dq_out_q    <= 16'd0;
         dq_oe_q     <= 1'b0;
         we_n_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_wr_q     <= op_wr_d;
         word_q      <= word_d;
         wdata_hi_q  <= wdata_hi_d;
         read_data_q <= read_data_d;
         sram_addr_q <= sram_addr_d;
         dq_out_q    <= dq_out_d;
         dq_oe_q     <= dq_oe_d;
         we_n_q      <= we_n_d;
      end
   end

   assign bus.ready       = (state_q == DONE) | ((state_q == IDLE) & ~req);
   assign bus.read_data   = read_data_q;
   assign bus.sram_addr   = sram_addr_q;
   assign bus.sram_dq_out = dq_out_q;
   assign bus.sram_dq_oe  = dq_oe_q;
   assign bus.sram_we_n   = we_n_q;
endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM, shadow memory and a
// scoreboard of expected read_data values popped on each DONE cycle.
module tb_sram_controller;
   localparam int WC   = 2;
   localparam int BASE = 1024;

   logic clk = 1'b0;
   logic rst;
   logic clr_mem;
   always #5 clk = ~clk;

   sram_controller_if bus();

   sram_controller #(.WAIT_CYCLES(WC), .BASE_ADDR(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [15:0] mem    [0:1023];
   logic [15:0] shadow [0:1023];

   assign bus.sram_dq_in = mem[bus.sram_addr[9:0]];

   always @(posedge clk) begin
      if (clr_mem) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 16'd0;
      end else if (!bus.sram_we_n) begin
         mem[bus.sram_addr[9:0]] <= bus.sram_dq_out;
      end
   end

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Entered and left at #1 after a rising edge; cycle 0 is the cycle the request is driven.
   task automatic run_req(input bit wr, input bit rd, input logic [31:0] addr,
                          input logic [31:0] data, input bit drop, input bit keep);
      logic [17:0] lo;
      logic [9:0]  il, ih;
      bit          act;
      logic [31:0] want;
      lo = 18'(((addr - 32'(BASE)) >> 2) << 1);
      il = lo[9:0];
      ih = {lo[9:1], 1'b1};
      if (wr) begin
         shadow[il] = data[15:0];
         shadow[ih] = data[31:16];
      end else begin
         exp_rd = {shadow[ih], shadow[il]};
      end
      exp_q.push_back(exp_rd);
      bus.wr_en = wr; bus.rd_en = rd; bus.address = addr; bus.write_data = data;
      for (int c = 0; c <= 2*WC + 1; c++) begin
         @(negedge clk);
         act = (c >= 1) && (c <= 2*WC);
         chk("ready", 32'(bus.ready), 32'(c == 2*WC + 1));
         chk("we_n", 32'(bus.sram_we_n), 32'(!(act && wr)));
         chk("oe", 32'(bus.sram_dq_oe), 32'(act && wr));
         if (act) begin
            chk("sram_addr", 32'(bus.sram_addr), (c <= WC) ? 32'(lo) : 32'(lo | 18'd1));
            if (wr) chk("dq_out", 32'(bus.sram_dq_out), (c <= WC) ? 32'(data[15:0]) : 32'(data[31:16]));
         end
         if (c == 2*WC + 1) begin
            chk("sb_size", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
               want = exp_q.pop_front();
               chk("read_data", bus.read_data, want);
            end
         end
         @(posedge clk); #1;
         if (c == 0 && drop) begin bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = 32'hFFFF_0000; end
      end
      if (!keep) begin bus.wr_en = 1'b0; bus.rd_en = 1'b0; end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) shadow[i] = 16'd0;
      exp_rd = 32'd0;
      rst = 1'b1; clr_mem = 1'b1;
      bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = 32'd0; bus.write_data = 32'd0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; clr_mem = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(bus.ready), 32'd1);
      chk("rst_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("rst_read_data", bus.read_data, 32'd0);
      chk("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
      chk("rst_dq_out", 32'(bus.sram_dq_out), 32'd0);
      @(posedge clk); #1;

      // Reset while the high half of a write is on the bus.
      bus.wr_en = 1'b1; bus.address = 32'd1536; bus.write_data = 32'hCAFE_F00D;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("pre_rst_addr", 32'(bus.sram_addr), 32'd257);
      chk("pre_rst_we_n", 32'(bus.sram_we_n), 32'd0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; bus.wr_en = 1'b0;
      shadow[256] = 16'hF00D; shadow[257] = 16'hCAFE;
      @(negedge clk);
      chk("mid_rst_we_n", 32'(bus.sram_we_n), 32'd1);
      chk("mid_rst_oe", 32'(bus.sram_dq_oe), 32'd0);
      chk("mid_rst_read_data", bus.read_data, 32'd0);
      chk("mid_rst_ready", 32'(bus.ready), 32'd1);
      @(posedge clk); #1;

      run_req(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 1'b0, 1'b0);
      run_req(1'b0, 1'b1, 32'd1024, 32'd0,         1'b0, 1'b0);
      run_req(1'b0, 1'b1, 32'd1028, 32'd0,         1'b0, 1'b0);
      run_req(1'b1, 1'b1, 32'd1030, 32'h1234_5678, 1'b0, 1'b0);
      run_req(1'b0, 1'b1, 32'd1028, 32'd0,         1'b1, 1'b0);
      @(negedge clk);
      chk("idle_ready", 32'(bus.ready), 32'd1);
      @(posedge clk); #1;

      // rd_en held through DONE: ready is high for exactly the DONE cycle.
      run_req(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0, 1'b1);
      run_req(1'b0, 1'b1, 32'd1030, 32'd0, 1'b0, 1'b0);

      // Address below BASE wraps and aliases.
      run_req(1'b1, 1'b0, 32'd0, 32'hA5A5_5A5A, 1'b0, 1'b0);
      run_req(1'b0, 1'b1, 32'd0, 32'd0,         1'b0, 1'b0);
      @(negedge clk);
      chk("end_ready", 32'(bus.ready), 32'd1);
      chk("end_read_data", bus.read_data, 32'hA5A5_5A5A);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
